alu_test_driver: RTL

//  Self-checking stimulus source and result checker for the registered N-bit ALU test harness.
//  On start, sweeps every opcode 0..NUM_OPS-1 against every operand 0..2^N-1.

---
 rtl/alu_test_driver_if.sv | 37 +++
 rtl/alu_test_driver.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/alu_test_driver_if.sv
`default_nettype none
// ============================================================================
//  Module : alu_test_driver_if
//  Brief  : Control, result and harness-facing bus of the ALU test driver.
//           master = the driver, slave = lab top / bench side.
//  Rev    : 1.0  initial release
// ============================================================================
interface alu_test_driver_if #(
    parameter int N     = 4,
    parameter int ERR_W = 8
);
    logic             start;
    logic [N-1:0]     dut_out;
    logic [N-1:0]     dut_in;
    logic [3:0]       dut_control;
    logic             busy;
    logic             done;
    logic             pass;
    logic [ERR_W-1:0] err_count;
    logic [3:0]       fail_ctrl;
    logic [N-1:0]     fail_operand;
    logic [N-1:0]     fail_got;
    logic [N-1:0]     fail_exp;

    modport master (
        input  start, dut_out,
        output dut_in, dut_control, busy, done, pass, err_count,
               fail_ctrl, fail_operand, fail_got, fail_exp
    );

    modport slave (
        output start, dut_out,
        input  dut_in, dut_control, busy, done, pass, err_count,
               fail_ctrl, fail_operand, fail_got, fail_exp
    );
endinterface
`default_nettype wire

// File: rtl/alu_test_driver.sv
`default_nettype none
// ============================================================================
//  Module : alu_test_driver
//  Brief  : Sweeps every opcode against every operand of a registered N-bit
//           ALU harness (a=b=operand), checks each result against a golden
//           model, counts mismatches and captures the first failure.
//  Rev    : 1.0  initial release
// ============================================================================
module alu_test_driver #(
    parameter int N       = 4,
    parameter int LAT     = 2,   // update edge -> valid dut_out, must be >= 1
    parameter int NUM_OPS = 8,   // 1..8
    parameter int ERR_W   = 8
) (
    input  wire logic         tclk,
    input  wire logic         reset,
    alu_test_driver_if.master drv
);

    localparam int               WC_W      = $clog2(LAT + 2);
    localparam logic [WC_W-1:0]  WC_ONE    = WC_W'(1);
    localparam logic [WC_W-1:0]  WC_LAT    = WC_W'(LAT);
    localparam logic [N-1:0]     LAST_X    = '1;
    localparam logic [N-1:0]     ONE_X     = N'(1);
    localparam logic [N-1:0]     SHIFT_LIM = N'(N);
    localparam logic [2:0]       LAST_OP   = 3'(NUM_OPS - 1);
    localparam logic [ERR_W-1:0] ERR_ONE   = ERR_W'(1);
    localparam logic [ERR_W-1:0] ERR_MAX   = '1;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_DRIVE = 3'd1,
        S_WAIT  = 3'd2,
        S_CHECK = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t           state_q;
    logic [2:0]       op_q;
    logic [N-1:0]     operand_q;
    logic [WC_W-1:0]  wait_q;
    logic [N-1:0]     dut_in_q;
    logic [3:0]       dut_ctrl_q;
    logic             busy_q;
    logic             done_q;
    logic             pass_q;
    logic [ERR_W-1:0] err_q;
    logic [3:0]       fail_ctrl_q;
    logic [N-1:0]     fail_operand_q;
    logic [N-1:0]     fail_got_q;
    logic [N-1:0]     fail_exp_q;

    logic [2:0]       op_d;
    logic [N-1:0]     operand_d;
    logic [N-1:0]     golden_val;
    logic             mismatch;
    logic             last_vec;

    // Expected ALU result when the harness feeds x to both a and b.
    function automatic logic [N-1:0] golden(input logic [2:0] op, input logic [N-1:0] x);
        logic [2*N-1:0] sq;
        logic [N-1:0]   res;
        sq = {{N{1'b0}}, x} * {{N{1'b0}}, x};
        case (op)
            3'd0:       res = x + x;
            3'd1:       res = '0;
            3'd2, 3'd3: res = x;
            3'd4:       res = '0;
            3'd5:       res = (x >= SHIFT_LIM) ? '0 : (x << x);
            3'd6:       res = (x >= SHIFT_LIM) ? '0 : (x >> x);
            default:    res = sq[N-1:0];
        endcase
        return res;
    endfunction

    // Golden compare for the current vector and the next vector in sweep order
    // (operand is the inner loop).
    always_comb begin
        golden_val = golden(op_q, operand_q);
        mismatch   = (drv.dut_out != golden_val);
        last_vec   = (op_q == LAST_OP) && (operand_q == LAST_X);
        if (operand_q == LAST_X) begin
            operand_d = '0;
            op_d      = op_q + 3'd1;
        end else begin
            operand_d = operand_q + ONE_X;
            op_d      = op_q;
        end
    end

    // Sweep FSM with all outputs registered; the vector registers only change
    // on a DRIVE entry edge because the harness does not register control.
    always_ff @(posedge tclk) begin
        if (reset) begin
            state_q        <= S_IDLE;
            op_q           <= '0;
            operand_q      <= '0;
            wait_q         <= '0;
            dut_in_q       <= '0;
            dut_ctrl_q     <= '0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
            pass_q         <= 1'b0;
            err_q          <= '0;
            fail_ctrl_q    <= '0;
            fail_operand_q <= '0;
            fail_got_q     <= '0;
            fail_exp_q     <= '0;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (drv.start) begin
                        state_q        <= S_DRIVE;
                        op_q           <= '0;
                        operand_q      <= '0;
                        wait_q         <= WC_ONE;
                        dut_in_q       <= '0;
                        dut_ctrl_q     <= '0;
                        busy_q         <= 1'b1;
                        done_q         <= 1'b0;
                        pass_q         <= 1'b0;
                        err_q          <= '0;
                        fail_ctrl_q    <= '0;
                        fail_operand_q <= '0;
                        fail_got_q     <= '0;
                        fail_exp_q     <= '0;
                    end
                end
                S_DRIVE: begin
                    // LAT==1 has no WAIT cycle at all
                    state_q <= (wait_q == WC_LAT) ? S_CHECK : S_WAIT;
                    if (wait_q != WC_LAT) begin
                        wait_q <= wait_q + WC_ONE;
                    end
                end
                S_WAIT: begin
                    if (wait_q == WC_LAT) begin
                        state_q <= S_CHECK;
                    end else begin
                        wait_q <= wait_q + WC_ONE;
                    end
                end
                S_CHECK: begin
                    if (mismatch) begin
                        if (err_q != ERR_MAX) begin
                            err_q <= err_q + ERR_ONE;
                        end
                        if (err_q == '0) begin
                            fail_ctrl_q    <= dut_ctrl_q;
                            fail_operand_q <= operand_q;
                            fail_got_q     <= drv.dut_out;
                            fail_exp_q     <= golden_val;
                        end
                    end
                    if (last_vec) begin
                        // vector registers keep the last vector in DONE
                        state_q <= S_DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        pass_q  <= !mismatch && (err_q == '0);
                    end else begin
                        state_q    <= S_DRIVE;
                        op_q       <= op_d;
                        operand_q  <= operand_d;
                        dut_in_q   <= operand_d;
                        dut_ctrl_q <= {1'b0, op_d};
                        wait_q     <= WC_ONE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // Drive the bus straight from the registers.
    always_comb begin
        drv.dut_in       = dut_in_q;
        drv.dut_control  = dut_ctrl_q;
        drv.busy         = busy_q;
        drv.done         = done_q;
        drv.pass         = pass_q;
        drv.err_count    = err_q;
        drv.fail_ctrl    = fail_ctrl_q;
        drv.fail_operand = fail_operand_q;
        drv.fail_got     = fail_got_q;
        drv.fail_exp     = fail_exp_q;
    end

endmodule
`default_nettype wire
